apb_slave_mem: RTL



---
 rtl/apb_slv_pkg.sv | 16 +
 rtl/apb_slave_mem_if.sv | 34 +++
 rtl/apb_slv_regfile.sv | 35 +++
 rtl/apb_slave_mem.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB3 completer memory.
// Address decode and the error rule live here so the top and the bench agree on one definition.
package apb_slv_pkg;

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam int ADDR_LSB       = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;

  // An access is in error when it is not word aligned or its word index is past the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[ADDR_LSB-1:0] != '0) || ((addr >> ADDR_LSB) >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between initiator and completer.
// Optional APB_SLV_PSTRB_EN adds the pstrb byte-lane strobes.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
    output pstrb,
`endif
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  pstrb,
`endif
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slv_regfile.sv
// Word array with byte-lane synchronous write, synchronous clear and asynchronous read.
// Out-of-range indices read as zero and never write.
module apb_slv_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  in_range;

  assign in_range = ({1'b0, idx_i} < (IDX_W+1)'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we_i && in_range) begin
      for (int b = 0; b < SW; b++)
        if (be_i[b]) mem[idx_i[MW-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = in_range ? mem[idx_i[MW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed memory with WAIT_CYCLES access-phase wait states.
// Define APB_SLV_PSTRB_EN to honour pstrb byte lanes on writes.
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             pclk,
  input  logic             preset,
  apb_slave_mem_if.slave   bus
);
  localparam int IDX_W = ADDR_WIDTH - ADDR_LSB;
  localparam int SW    = DATA_WIDTH / 8;
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;

  logic [IDX_W-1:0]      idx_in, rd_idx;
  logic                  err_in;
  logic [SW-1:0]         strb_in;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  we;

  assign idx_in = bus.paddr[ADDR_WIDTH-1:ADDR_LSB];
  assign err_in = addr_err(32'(bus.paddr), MEM_DEPTH);
  // Zero-wait reads must see the array at the setup edge, before the index is captured.
  assign rd_idx = (state_q == IDLE) ? idx_in : idx_q;

`ifdef APB_SLV_PSTRB_EN
  assign strb_in = bus.pstrb;
`else
  assign strb_in = '1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          idx_d   = idx_in;
          write_d = bus.pwrite;
          err_d   = err_in;
          wdata_d = bus.pwdata;
          strb_d  = strb_in;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = err_in;
            prdata_d  = (bus.pwrite || err_in) ? '0 : rdata;
          end
        end
      end
      ACCESS: begin
        if (bus.psel && bus.penable) begin
          if (pready_q) begin
            we        = write_q && !err_q;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = IDLE;
          end else if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d     = '0;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (write_q || err_q) ? '0 : rdata;
          end
        end else begin
          // Initiator abandoned the transfer before completion.
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge pclk) begin
    idx_q   <= idx_d;
    write_q <= write_d;
    err_q   <= err_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
  end

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (pclk),
    .clr_i   (preset),
    .we_i    (we),
    .be_i    (strb_q),
    .idx_i   (rd_idx),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule
